// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Define MC_CTRL_WAIT_EN to enable the mem_ready handshake, wait counter and bus_err.
module mc_control #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       Jr,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JR     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_limit
        $error("mc_control: WAIT_LIMIT must be 1..255");
    end

    state_t state_q, state_d;
    logic   rdy;
    logic   abort;
    logic   op_legal;
    state_t dec_nxt;
    logic [2:0] imm_aluop;

`ifdef MC_CTRL_WAIT_EN
    localparam logic [7:0] LIMIT = WAIT_LIMIT[7:0];

    logic [7:0] wait_q, wait_d;
    logic       mem_st;

    assign rdy = mem_ready;

    always_comb begin
        mem_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                 (state_q == S_MEMWR);
        abort  = mem_st && !mem_ready && (wait_q == LIMIT);
    end

    // Any state change or abort re-arms the counter for the next access.
    always_comb begin
        wait_d = wait_q;
        if (abort || (state_d != state_q)) begin
            wait_d = '0;
        end else if (mem_st && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign rdy   = mem_ready | 1'b1;
    assign abort = 1'b0;
`endif

    always_comb begin
        op_legal = 1'b1;
        dec_nxt  = S_FETCH;
        case (op)
            OP_LW, OP_SW:             dec_nxt = S_MEMADR;
            OP_RTYPE:                 dec_nxt = S_EXEC;
            OP_BEQ:                   dec_nxt = S_BRANCH;
            OP_J:                     dec_nxt = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: dec_nxt = S_IMMEX;
            default:                  op_legal = 1'b0;
        endcase
    end

    // IR is not rewritten until the next FETCH, so IMMWB can re-derive this.
    always_comb begin
        case (op)
            OP_ANDI: imm_aluop = 3'b100;
            OP_ORI:  imm_aluop = 3'b101;
            default: imm_aluop = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (abort) begin
                    state_d = S_FETCH;
                end else if (rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = dec_nxt;
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (abort) begin
                    state_d = S_FETCH;
                end else if (rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (abort || rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = Jr ? S_JR : S_RWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IMMWB, S_JR: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are forced low while reset is held, even though state reads FETCH.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 3'b000;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        if (reset_n) begin
            bus_err = abort;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = rdy && !abort;
                    PCWrite = rdy && !abort;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    illegal = !op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = !abort;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b010;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 3'b001;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_IMMEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = imm_aluop;
                end
                S_IMMWB: begin
                    RegWrite = 1'b1;
                    ALUOp    = imm_aluop;
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected control words queued
// by the driver and popped/compared by a negedge monitor.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rw;
        logic       rdst;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
        logic       berr;
    } obs_t;

    typedef struct {
        obs_t  e;
        string tag;
    } sb_t;

    localparam obs_t ZERO    = '0;
    localparam obs_t F_RDY   = '{st:4'd0, pcw:1'b1, mrd:1'b1, irw:1'b1, srcb:2'b01, default:'0};
    localparam obs_t F_WAIT  = '{st:4'd0, mrd:1'b1, srcb:2'b01, default:'0};
    localparam obs_t DEC     = '{st:4'd1, srcb:2'b11, default:'0};
    localparam obs_t DEC_ILL = '{st:4'd1, srcb:2'b11, ill:1'b1, default:'0};
    localparam obs_t MADR    = '{st:4'd2, srca:1'b1, srcb:2'b10, default:'0};
    localparam obs_t MRD     = '{st:4'd3, mrd:1'b1, iord:1'b1, default:'0};
    localparam obs_t MWB     = '{st:4'd4, rw:1'b1, m2r:1'b1, default:'0};
    localparam obs_t MWR     = '{st:4'd5, mwr:1'b1, iord:1'b1, default:'0};
    localparam obs_t MWR_AB  = '{st:4'd5, iord:1'b1, berr:1'b1, default:'0};
    localparam obs_t EXE     = '{st:4'd6, srca:1'b1, aluop:3'b010, default:'0};
    localparam obs_t RWB     = '{st:4'd7, rw:1'b1, rdst:1'b1, default:'0};
    localparam obs_t BR      = '{st:4'd8, srca:1'b1, aluop:3'b001, pcwc:1'b1, pcsrc:2'b01, default:'0};
    localparam obs_t JMP     = '{st:4'd9, pcw:1'b1, pcsrc:2'b10, default:'0};
    localparam obs_t JRS     = '{st:4'd12, pcw:1'b1, pcsrc:2'b11, default:'0};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       Jr;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       illegal, bus_err;

    obs_t obs;
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [5:0] nxt_op = 6'd0;
    logic       nxt_jr = 1'b0;

    mc_control #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .Jr(Jr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                  IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB,
                  PCSource, ALUOp, illegal, bus_err};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t it;
        if (sb_q.size() != 0) begin
            it = sb_q.pop_front();
            check(it.tag, 32'(obs), 32'(it.e));
        end
    end

    task automatic cyc(input obs_t e, input logic rdy, input logic rn,
                       input string tag);
        sb_t it;
        @(posedge clk);
        #1;
        reset_n   = rn;
        mem_ready = rdy;
        op        = nxt_op;
        Jr        = nxt_jr;
        it.e      = e;
        it.tag    = tag;
        sb_q.push_back(it);
    endtask

    task automatic c(input obs_t e, input string tag);
        cyc(e, 1'b1, 1'b1, tag);
    endtask

    task automatic w(input obs_t e, input string tag);
        cyc(e, 1'b0, 1'b1, tag);
    endtask

    task automatic set(input logic [5:0] o, input logic j);
        nxt_op = o;
        nxt_jr = j;
    endtask

    function automatic obs_t imx(input logic [2:0] a);
        obs_t r = '{st:4'd10, srca:1'b1, srcb:2'b10, default:'0};
        r.aluop = a;
        return r;
    endfunction

    function automatic obs_t imwb(input logic [2:0] a);
        obs_t r = '{st:4'd11, rw:1'b1, default:'0};
        r.aluop = a;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; op = '0; Jr = 1'b0; mem_ready = 1'b0;
        cyc(ZERO, 1'b0, 1'b0, "rst_a");
        cyc(ZERO, 1'b1, 1'b0, "rst_b");

        set(OP_LW, 0);
        c(F_RDY, "lw_f"); c(DEC, "lw_d"); c(MADR, "lw_a");
        c(MRD, "lw_r"); c(MWB, "lw_wb");
        set(OP_SW, 0);
        c(F_RDY, "sw_f"); c(DEC, "sw_d"); c(MADR, "sw_a"); c(MWR, "sw_w");
        set(OP_R, 0);
        c(F_RDY, "add_f"); c(DEC, "add_d"); c(EXE, "add_x"); c(RWB, "add_wb");
        set(OP_R, 1);
        c(F_RDY, "jr_f"); c(DEC, "jr_d"); c(EXE, "jr_x"); c(JRS, "jr_pc");
        set(OP_BEQ, 0);
        c(F_RDY, "beq_f"); c(DEC, "beq_d"); c(BR, "beq_b");
        set(OP_J, 0);
        c(F_RDY, "j_f"); c(DEC, "j_d"); c(JMP, "j_j");
        set(OP_ADDI, 0);
        c(F_RDY, "addi_f"); c(DEC, "addi_d");
        c(imx(3'b000), "addi_x"); c(imwb(3'b000), "addi_wb");
        set(OP_ANDI, 0);
        c(F_RDY, "andi_f"); c(DEC, "andi_d");
        c(imx(3'b100), "andi_x"); c(imwb(3'b100), "andi_wb");
        set(OP_ORI, 0);
        c(F_RDY, "ori_f"); c(DEC, "ori_d");
        c(imx(3'b101), "ori_x"); c(imwb(3'b101), "ori_wb");
        set(6'b111111, 0);
        c(F_RDY, "ill_f"); c(DEC_ILL, "ill_d");
        set(6'b000011, 0);
        c(F_RDY, "ill2_f"); c(DEC_ILL, "ill2_d");

`ifdef MC_CTRL_WAIT_EN
        set(OP_SW, 0);
        c(F_RDY, "swt_f"); c(DEC, "swt_d"); c(MADR, "swt_a");
        for (int i = 0; i < 3; i++) w(MWR, "swt_wait");
        c(MWR, "swt_done");
        set(OP_BEQ, 0);
        w(F_WAIT, "fw_0"); w(F_WAIT, "fw_1");
        c(F_RDY, "fw_f"); c(DEC, "fw_d"); c(BR, "fw_b");
        set(OP_SW, 0);
        c(F_RDY, "to_f"); c(DEC, "to_d"); c(MADR, "to_a");
        for (int i = 0; i < 15; i++) w(MWR, "to_wait");
        w(MWR_AB, "to_abort");
        set(OP_LW, 0);
        c(F_RDY, "lim_f"); c(DEC, "lim_d"); c(MADR, "lim_a");
        for (int i = 0; i < 15; i++) w(MRD, "lim_wait");
        c(MRD, "lim_rdy"); c(MWB, "lim_wb");
`endif

        set(OP_LW, 0);
        c(F_RDY, "mr_f"); c(DEC, "mr_d"); c(MADR, "mr_a");
        w(MRD, "mr_pend");
        cyc(ZERO, 1'b0, 1'b0, "mr_rst");
        cyc(ZERO, 1'b1, 1'b0, "mr_rst2");
        set(OP_J, 0);
        c(F_RDY, "re_f"); c(DEC, "re_d"); c(JMP, "re_j");

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control FSM for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. Each step drives the datapath mux selects, the write enables and the 3-bit `ALUOp` consumed by the ALU control unit. The block sits between the instruction register opcode field and the shared ALU, register file, PC and unified memory. Memory accesses wait on a ready handshake with a bounded timeout.

## Interface
- `WAIT_LIMIT`, 15: maximum cycles spent in one memory state before abort (1..255).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26], valid from DECODE onward.
- `Jr` in 1: jump-register flag from ALU control, sampled in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `ALUOp` out 3: 000 add, 001 sub, 010 R-type funct, 100 and, 101 or.
- `state` out 4: current state, for debug.
- `illegal` out 1: one-cycle pulse, unknown opcode.
- `bus_err` out 1: one-cycle pulse, memory timeout.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, JR=12
  - Encodings 13–15 go to FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=000, `PCSource`=00.
  - `IRWrite` and `PCWrite` are asserted only in the cycle `mem_ready`=1; that cycle moves to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=000 (branch target into ALUOut). Next state by `op`:
  - 100011 / 101011 (lw/sw) → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 / 001100 / 001101 → IMMEX
  - any other opcode → FETCH with `illegal`=1 for that cycle
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. On `mem_ready` → MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0 → FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. On `mem_ready` → FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010. Goes to JR if `Jr`=1, else RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0 → FETCH.
- JR: `PCWrite`=1, `PCSource`=11, no register write → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=001, `PCWriteCond`=1, `PCSource`=01 → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10 → FETCH.
- IMMEX: `ALUSrcA`=1, `ALUSrcB`=10. `ALUOp` is 000 for addi, 100 for andi, 101 for ori.
- IMMWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. `ALUOp` is held at the IMMEX value → FETCH.
- Every control not listed for a state is 0.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle the block stays in one of those states without `mem_ready`.
  - When the count reaches `WAIT_LIMIT` with `mem_ready`=0, `bus_err` pulses and the state goes to FETCH.
  - The aborting cycle asserts no write enable: no `PCWrite`, `IRWrite` or `MemWrite`.
- `mem_ready` arriving in the same cycle as the limit: ready wins, the access completes and there is no `bus_err`.

## Timing
- Reset:
  - `reset_n` low forces `state`=FETCH and the wait counter to 0, asynchronously.
  - While low, all write enables, `MemRead`, `illegal` and `bus_err` are 0; every other output is 0 as well.
- After release, the first FETCH read is issued on the first rising edge with `reset_n`=1.
- Zero-wait cycle counts:
  - lw = 5
  - sw = 4
  - R-type = 4
  - jr = 4
  - addi/andi/ori = 4
  - beq = 3
  - j = 3
  - illegal = 2
- Each wait cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
- Reset mid-instruction abandons it; a partial write is never completed.
- Outputs are decoded combinationally from `state`, plus `mem_ready` for the FETCH/MEMWR strobes. The next state is registered.

## Configuration
- `MC_CTRL_WAIT_EN` defined: `mem_ready` handshake, wait counter and `bus_err` behave as above.
- Not defined:
  - `mem_ready` is ignored and treated as 1, so every memory state lasts exactly 1 cycle.
  - The wait counter is removed and `bus_err` is tied to 0.

## Test plan
- lw (op=100011), `mem_ready`=1 constant → `state` sequence 0,1,2,3,4,0. `RegWrite`=1 with `MemtoReg`=1 only in cycle 5.
- R-type add then jr (`Jr`=1 in EXEC):
  - add → states 0,1,6,7,0 with `ALUOp`=010 in EXEC and `RegDst`=1.
  - jr → 0,1,6,12,0 with `PCWrite`=1 and `PCSource`=11 in state 12.
- beq and ori:
  - beq → `ALUOp`=001 and `PCWriteCond`=1 in state 8.
  - ori (001101) → `ALUOp`=101 in states 10 and 11, `RegWrite` in state 11.
- op=111111 → `illegal` pulses 1 cycle in DECODE, next state 0, no write enable asserted.
- With `MC_CTRL_WAIT_EN` and `WAIT_LIMIT`=15:
  - sw with `mem_ready` low for 3 cycles → `MemWrite` held 4 cycles, completes.
  - `mem_ready` held low → `bus_err` after 15 wait cycles, return to FETCH, `MemWrite` never accepted.
- Assert `reset_n`=0 in MEMRD with a pending wait → immediate `state`=0 and all enables 0. Fetch restarts after release.
